// File: rtl/weight_fifo_loader_if.sv
// Host row stream and weight-FIFO write port seen by the weight FIFO loader.
// The loader takes the slave side; the host/bench drives the master side.
interface weight_fifo_loader_if #(
  parameter int WEIGHT_BW   = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int NUM_PE_ROWS = 8
);
  localparam int ROW_W  = WEIGHT_BW * MATRIX_SIZE;
  localparam int TILE_W = ROW_W * NUM_PE_ROWS;

  logic              in_valid;
  logic              in_ready;
  logic [ROW_W-1:0]  in_data;
  logic              fifo_full;
  logic              fifo_write_enable;
  logic [TILE_W-1:0] fifo_data_in;

  modport slave (
    input  in_valid, in_data, fifo_full,
    output in_ready, fifo_write_enable, fifo_data_in
  );

  modport master (
    output in_valid, in_data, fifo_full,
    input  in_ready, fifo_write_enable, fifo_data_in
  );
endinterface

// File: rtl/weight_fifo_loader.sv
// Packs NUM_PE_ROWS host weight rows into one tile and writes it to the weight
// FIFO with a single strobe, waiting while the FIFO reports full.
module weight_fifo_loader #(
  parameter int WEIGHT_BW   = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int NUM_PE_ROWS = 8,
  parameter int CNT_BW      = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  weight_fifo_loader_if.slave     bus,
  input  logic                    flush,
  output logic                    busy,
  output logic [CNT_BW-1:0]       tile_count
);
  localparam int ROW_W  = WEIGHT_BW * MATRIX_SIZE;
  localparam int TILE_W = ROW_W * NUM_PE_ROWS;
  localparam int BC_W   = (NUM_PE_ROWS > 1) ? $clog2(NUM_PE_ROWS) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(NUM_PE_ROWS - 1);

  typedef enum logic {FILL, PUSH} state_t;

  state_t            state, state_nxt;
  logic [BC_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [TILE_W-1:0] tile;
  logic              xfer;
  logic              wr_strobe;

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    bus.in_ready = (state == FILL) && !flush;
    wr_strobe    = (state == PUSH) && !bus.fifo_full && !flush;
    xfer         = bus.in_valid && bus.in_ready;
    if (flush) begin
      state_nxt    = FILL;
      beat_cnt_nxt = '0;
    end else begin
      case (state)
        FILL: if (xfer) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            state_nxt    = PUSH;
          end else begin
            beat_cnt_nxt = beat_cnt + BC_W'(1);
          end
        end
        PUSH: if (wr_strobe) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= FILL;
      beat_cnt   <= '0;
      tile_count <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (wr_strobe) tile_count <= tile_count + CNT_BW'(1);
    end
  end

  // Row r is only written by the beat that lands in slot r; slots are never
  // cleared between tiles because every slot is rewritten before the next push.
  for (genvar r = 0; r < NUM_PE_ROWS; r++) begin : g_row
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        tile[r*ROW_W +: ROW_W] <= '0;
      end else if (xfer && (beat_cnt == BC_W'(r))) begin
        tile[r*ROW_W +: ROW_W] <= bus.in_data;
      end
    end
  end

  assign bus.fifo_data_in      = tile;
  assign bus.fifo_write_enable = wr_strobe;
  assign busy                  = (state == PUSH) || (beat_cnt != '0);
endmodule

// File: tb/tb_weight_fifo_loader.sv
// Randomised scoreboard bench for weight_fifo_loader: tiles are assembled from
// accepted rows by the bench and checked whenever the FIFO write strobe fires.
module tb_weight_fifo_loader;
  localparam int WEIGHT_BW   = 8;
  localparam int MATRIX_SIZE = 8;
  localparam int NUM_PE_ROWS = 8;
  localparam int CNT_BW      = 8;
  localparam int ROW_W       = WEIGHT_BW * MATRIX_SIZE;
  localparam int TILE_W      = ROW_W * NUM_PE_ROWS;

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush;
  logic              busy;
  logic [CNT_BW-1:0] tile_count;

  weight_fifo_loader_if #(.WEIGHT_BW(WEIGHT_BW), .MATRIX_SIZE(MATRIX_SIZE),
                          .NUM_PE_ROWS(NUM_PE_ROWS)) bus ();

  weight_fifo_loader #(.WEIGHT_BW(WEIGHT_BW), .MATRIX_SIZE(MATRIX_SIZE),
                       .NUM_PE_ROWS(NUM_PE_ROWS), .CNT_BW(CNT_BW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .flush      (flush),
    .busy       (busy),
    .tile_count (tile_count)
  );

  always #5 clk = ~clk;

  logic [TILE_W-1:0] sb[$];
  logic [ROW_W-1:0]  rows[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_strobe = 0;
  int n_stall = 0;
  int exp_cnt = 0;

  task automatic chk(input string nm, input logic [TILE_W-1:0] act, input logic [TILE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: collect accepted rows; a full set forms one expected tile.
  task automatic model_accept(input logic [ROW_W-1:0] row);
    logic [TILE_W-1:0] t;
    rows.push_back(row);
    if (rows.size() == NUM_PE_ROWS) begin
      t = '0;
      for (int i = 0; i < NUM_PE_ROWS; i++) t[i*ROW_W +: ROW_W] = rows[i];
      sb.push_back(t);
      exp_cnt++;
      rows.delete();
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send_beat(input logic [ROW_W-1:0] row);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = row;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
      n_stall++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("beat_accept_timeout", {{(TILE_W-1){1'b0}}, bus.in_ready}, 1);
    end else begin
      @(posedge clk);
      #1;
      model_accept(row);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending_tiles", TILE_W'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sb.delete();
    rows.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: every write strobe must match the oldest expected tile.
  always @(negedge clk) begin
    if (bus.fifo_write_enable === 1'b1) begin
      n_strobe++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_strobe: got 1 expected 0");
      end else begin
        chk("tile_data", bus.fifo_data_in, sb.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ROW_W-1:0] base, inc;
    int s0;
    base = 64'h0807060504030201;
    inc  = 64'h0808080808080808;
    rstn = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.fifo_full = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", TILE_W'(bus.fifo_write_enable), 0);
    chk("rst_data", bus.fifo_data_in, 0);
    chk("rst_busy", TILE_W'(busy), 0);
    chk("rst_tile_count", TILE_W'(tile_count), 0);
    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", TILE_W'(bus.in_ready), 1);
    @(posedge clk); #1;

    // 1: back-to-back tile, strobe one cycle after the last beat
    n_stall = 0;
    for (int k = 0; k < NUM_PE_ROWS; k++) send_beat(base + ROW_W'(k) * inc);
    @(negedge clk);
    chk("t1_stall_cycles", TILE_W'(n_stall), 0);
    chk("t1_strobe", TILE_W'(bus.fifo_write_enable), 1);
    chk("t1_row0", TILE_W'(bus.fifo_data_in[63:0]), TILE_W'(64'h0807060504030201));
    chk("t1_row7", TILE_W'(bus.fifo_data_in[511:448]), TILE_W'(64'h403F3E3D3C3B3A39));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_tile_count", TILE_W'(tile_count), 1);
    chk("t1_busy", TILE_W'(busy), 0);
    @(posedge clk); #1;

    // 2: FIFO full holds the tile in PUSH
    bus.fifo_full = 1'b1;
    for (int k = 0; k < NUM_PE_ROWS; k++) send_beat({$urandom, $urandom});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_strobe_held", TILE_W'(bus.fifo_write_enable), 0);
      chk("t2_in_ready", TILE_W'(bus.in_ready), 0);
      chk("t2_data_stable", bus.fifo_data_in, (sb.size() != 0) ? sb[0] : '0);
    end
    s0 = n_strobe;
    @(posedge clk); #1; bus.fifo_full = 1'b0;
    @(negedge clk);
    chk("t2_strobe", TILE_W'(bus.fifo_write_enable), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_single_strobe", TILE_W'(n_strobe - s0), 1);
    chk("t2_tile_count", TILE_W'(tile_count), TILE_W'(exp_cnt));
    @(posedge clk); #1;

    // 3: flush discards a partial tile
    do_reset();
    for (int k = 0; k < 3; k++) send_beat({$urandom, $urandom});
    @(negedge clk);
    chk("t3_busy_partial", TILE_W'(busy), 1);
    @(posedge clk); #1;
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = {$urandom, $urandom};
    @(negedge clk);
    chk("t3_ready_in_flush", TILE_W'(bus.in_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    rows.delete();
    @(negedge clk);
    chk("t3_busy_after_flush", TILE_W'(busy), 0);
    @(posedge clk); #1;
    for (int k = 0; k < NUM_PE_ROWS; k++) send_beat({$urandom, $urandom});
    drain();
    @(negedge clk);
    chk("t3_tile_count", TILE_W'(tile_count), 1);
    @(posedge clk); #1;

    // 4: flush in PUSH suppresses the write
    for (int k = 0; k < NUM_PE_ROWS; k++) send_beat({$urandom, $urandom});
    flush = 1'b1;
    void'(sb.pop_back());
    exp_cnt--;
    @(negedge clk);
    chk("t4_no_strobe", TILE_W'(bus.fifo_write_enable), 0);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("t4_busy", TILE_W'(busy), 0);
    chk("t4_in_ready", TILE_W'(bus.in_ready), 1);
    chk("t4_tile_count", TILE_W'(tile_count), TILE_W'(exp_cnt));
    @(posedge clk); #1;

    // 5: two tiles with random valid gaps
    s0 = n_strobe;
    for (int k = 0; k < 2 * NUM_PE_ROWS; k++) begin
      int g;
      g = $urandom_range(0, 3);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      send_beat({$urandom, $urandom});
    end
    drain();
    @(negedge clk);
    chk("t5_strobes", TILE_W'(n_strobe - s0), 2);
    chk("t5_tile_count", TILE_W'(tile_count), TILE_W'(exp_cnt));
    @(posedge clk); #1;

    // 6: async reset while a tile is pending
    bus.fifo_full = 1'b1;
    for (int k = 0; k < NUM_PE_ROWS; k++) send_beat({$urandom, $urandom});
    #1;
    rstn = 1'b0; bus.fifo_full = 1'b0;
    sb.delete(); rows.delete(); exp_cnt = 0;
    #1;
    chk("t6_strobe", TILE_W'(bus.fifo_write_enable), 0);
    chk("t6_tile_count", TILE_W'(tile_count), 0);
    chk("t6_data", bus.fifo_data_in, 0);
    chk("t6_busy", TILE_W'(busy), 0);
    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", TILE_W'(bus.in_ready), 1);
    @(posedge clk); #1;

    // 7: 256 tiles wrap the counter
    s0 = n_strobe;
    for (int t = 0; t < 256; t++) begin
      for (int k = 0; k < NUM_PE_ROWS; k++) send_beat({$urandom, $urandom});
      if (t == 254) begin
        drain();
        @(negedge clk);
        chk("t7_count_255", TILE_W'(tile_count), 255);
        @(posedge clk); #1;
      end
    end
    drain();
    @(negedge clk);
    chk("t7_count_wrap", TILE_W'(tile_count), 0);
    chk("t7_strobes", TILE_W'(n_strobe - s0), 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
